// File: rtl/dff_pipe_pkg.sv
// Shared constants and helpers for the elastic register pipeline.
package dff_pipe_pkg;
  localparam int DEF_WIDTH       = 8;
  localparam int DEF_DEPTH       = 3;
  localparam int DEF_RESET_VALUE = 0;

  // Occupancy counter width: enough to hold 0..depth, never narrower than 1.
  function automatic int COUNT_W(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/dff_pipe_stage.sv
// One valid/data register slot; advances when downstream is ready or it is empty.
module dff_pipe_stage #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             vin,
  input  logic [WIDTH-1:0] din,
  input  logic             rdy_dn,
  output logic             rdy,
  output logic             v,
  output logic [WIDTH-1:0] d
);
  // An empty slot always accepts, which is what collapses bubbles.
  assign rdy = ~v | rdy_dn;

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= 1'b0;
      d <= RESET_VALUE;
    end else if (flush) begin
      v <= 1'b0;
    end else if (rdy) begin
      v <= vin;
      if (vin) d <= din;
    end
  end
endmodule

// File: rtl/dff_pipe.sv
// WIDTH x DEPTH bubble-collapsing register pipeline with valid/ready, flush and occupancy.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter int               DEPTH       = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEF_RESET_VALUE)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  input  logic                        out_ready,
  input  logic                        flush,
  output logic [COUNT_W(DEPTH)-1:0]   count
);
  localparam int CW = COUNT_W(DEPTH);

  logic [DEPTH-1:0]            v;
  logic [DEPTH:0]              r;
  logic [DEPTH-1:0][WIDTH-1:0] d;
  logic                        in_xfer, out_xfer;
  logic [CW-1:0]               cnt;

  assign r[DEPTH] = out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stg
    logic             vin;
    logic [WIDTH-1:0] din;
    if (k == 0) begin : g_head
      assign vin = in_valid;
      assign din = in_data;
    end else begin : g_body
      assign vin = v[k-1];
      assign din = d[k-1];
    end
    dff_pipe_stage #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_stg (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .vin    (vin),
      .din    (din),
      .rdy_dn (r[k+1]),
      .rdy    (r[k]),
      .v      (v[k]),
      .d      (d[k])
    );
  end

  // Reset also masks the handshake so a beat is never counted as moved on a dropping edge.
  assign in_ready  = r[0] & ~flush & ~rst;
  assign out_valid = v[DEPTH-1] & ~flush & ~rst;
  assign out_data  = d[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush)            cnt <= '0;
    else if (in_xfer && !out_xfer) cnt <= cnt + CW'(1);
    else if (!in_xfer && out_xfer) cnt <= cnt - CW'(1);
  end

  assign count = cnt;
endmodule

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
- Parametrised successor to the single-bit gate-level D flip-flop used in the low-frequency blink path.
- Generalises one bit to a WIDTH-bit, DEPTH-stage register pipeline with a synchronous reset value, per-stage valid bits and valid/ready backpressure.
- Stages are bubble-collapsing, and the block has flush and occupancy reporting.
- Sits between processor-side producers (LED pattern and blink-rate logic, sampled GPIO) and slow consumers. Used for retiming and elastic buffering.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 3, number of register stages (>=1). This is also the unstalled latency.
- RESET_VALUE, 0, value loaded into every data register on reset (WIDTH bits).

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  producer has data on in_data.
- in_data  input  WIDTH  input payload.
- in_ready  output  1  pipe accepts in_data this cycle.
- out_valid  output  1  out_data holds a valid beat.
- out_data  output  WIDTH  output payload (last stage register).
- out_ready  input  1  consumer accepts this cycle.
- flush  input  1  discard all buffered beats.
- count  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Stage k (0..DEPTH-1) holds v[k] and d[k]. Stage 0 is the input side; stage DEPTH-1 drives the outputs.
- Ready chain: r[DEPTH] = out_ready; r[k] = ~v[k] | r[k+1].
- in_ready = r[0] & ~flush. The path from out_ready to in_ready is combinational by design.
- out_valid = v[DEPTH-1] & ~flush. out_data = d[DEPTH-1].
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- Stage update per clock when r[k]=1:
  - v[k] <= v[k-1], or in_valid for k=0.
  - d[k] <= d[k-1], or in_data for k=0. The data register loads only when the incoming valid is 1; otherwise it holds.
- A stage with r[k]=0 holds both v and d.
- Bubbles collapse: an empty stage always accepts from upstream even when downstream is stalled.
- Latency: a beat accepted at edge N is visible on out_valid after edge N+DEPTH if never stalled. Throughput is 1 beat/cycle.
- Full (all v=1, count=DEPTH):
  - out_ready=0 gives in_ready=0.
  - out_ready=1 gives in_ready=1 and a simultaneous in/out transfer; count is unchanged.
- Empty (count=0): out_valid=0 and in_ready=1 (when no flush).
- count <= count + in_xfer - out_xfer. It is a registered counter, not a popcount. It never exceeds DEPTH and never underflows.
- Flush (synchronous, level):
  - All v <= 0 and count <= 0 at the next edge.
  - in_ready and out_valid are forced 0 during the flush cycle, so no handshake completes.
  - Data registers are not cleared.
  - Flush and in_valid together: the input is not accepted and is not lost silently, because in_ready=0.
- Reset (synchronous, highest priority over flush and transfers):
  - All v <= 0, all d <= RESET_VALUE, count <= 0.
  - Outputs after the reset edge: out_valid=0, out_data=RESET_VALUE, in_ready=1, count=0.
  - Reset mid-stream drops all in-flight beats. Reset in the same cycle as in_valid accepts nothing.
- No X propagation: every register has a defined reset value.

Decomposition:
- Shared package dff_pipe_pkg:
  - COUNT_W function, returning $clog2(DEPTH+1) with a minimum of 1.
  - Default WIDTH, DEPTH and RESET_VALUE constants.
- One natural sub-module, dff_pipe_stage: a single valid/data register with ready-in/ready-out, reset value and flush. The top instantiates DEPTH of these in a generate loop and owns the occupancy counter.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 and in_data=0x5A. Required: no accept; out_valid=0, out_data=0x00, count=0, in_ready=1.
- Latency: DEPTH=3, out_ready=1, single beat 0xA5 at edge 0. Required: out_valid=1 with out_data=0xA5 exactly after edge 3, for one cycle; count goes 1,1,1 then 0 after the output transfer.
- Stream/backpressure:
  - With out_ready=0, push 0x01, 0x02, 0x03. Required: count=3 and in_ready=0.
  - Offer 0x04 while stalled. Required: not accepted.
  - Raise out_ready with in_valid held. Required: outputs 0x01, 0x02, 0x03, 0x04 on consecutive cycles, with 0x04 accepted in the same cycle 0x01 leaves.
- Bubble collapse: push 0x11, idle 2 cycles, push 0x22, all with out_ready=0. Required: both beats land in adjacent stages (count=2); on release they emit back-to-back.
- Flush: fill to count=2, then assert flush together with in_valid=1 and in_data=0x77. Required:
  - During the flush cycle: in_ready=0 and out_valid=0.
  - Next cycle: count=0, out_valid=0.
  - 0x77 never appears at the output.
- Reset mid-stream: full pipe at count=3, assert rst together with out_ready=1. Required: no output transfer that cycle; after the edge count=0 and out_data=RESET_VALUE.
